// File: rtl/crc_frame_gate.sv
// CRC frame gate: buffers frames and releases them only after a good CRC verdict.
// Optional CRC_FRAME_GATE_STRIP_EN zeroes the trailing CRC half of the last word.
module crc_frame_gate #(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        SyncIn,
    input  logic        DinNd,
    input  logic [31:0] Din,
    input  logic [3:0]  DinKeep,
    input  logic        CrcSync,
    input  logic        CrcOk,
    output logic        M_Valid,
    input  logic        M_Ready,
    output logic [31:0] M_Data,
    output logic [3:0]  M_Keep,
    output logic        M_Last,
    output logic        M_Sof,
    output logic [15:0] GoodCnt,
    output logic [15:0] BadCnt,
    output logic [15:0] OvfCnt,
    output logic        Busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(MAX_WORDS + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_VERDICT,
        S_ROLLBACK
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0]  r_commit_ptr;
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_crc_bad;
    logic [15:0]        r_good;
    logic [15:0]        r_bad;
    logic [15:0]        r_ovfc;

    logic [35:0]        r_mem [DEPTH];
    logic [DEPTH-1:0]   r_lastv;

    logic               r_s1_v;
    logic [35:0]        r_s1_word;
    logic               r_s1_last;
    logic               r_m_valid;
    logic [31:0]        r_m_data;
    logic [3:0]         r_m_keep;
    logic               r_m_last;
    logic               r_m_sof;
    logic               r_first;

    logic               w_full;
    logic               w_cnt_max;
    logic               w_abort;
    logic               w_take;
    logic               w_drop;
    logic               w_we;
    logic               w_wlast;
    logic               w_end;
    logic               w_mark;
    logic               w_commit;
    logic [ADDR_W-1:0]  w_commit_ptr;
    logic [ADDR_W-1:0]  w_prev_ptr;
    logic               w_avail;
    logic               w_out_ld;
    logic               w_s1_free;
    logic               w_rd;
    logic [31:0]        w_s1_data;
    logic [3:0]         w_s1_keep;

    assign w_full     = (r_wr_ptr + ADDR_W'(1)) == r_rd_ptr;
    assign w_cnt_max  = r_cnt == CNT_W'(MAX_WORDS);
    assign w_abort    = SyncIn && (r_state == S_RECV || r_state == S_VERDICT);
    assign w_take     = DinNd && ((r_state == S_IDLE && SyncIn) ||
                                  (r_state == S_RECV && !SyncIn));
    assign w_drop     = w_take && (r_ovf || w_full || w_cnt_max);
    assign w_we       = w_take && !w_drop;
    assign w_wlast    = (r_state == S_RECV) && CrcSync;
    assign w_end      = (r_state == S_RECV) && !SyncIn && CrcSync &&
                        (r_cnt != '0 || w_we || r_ovf || w_drop);
    // Tag the previous word only when this cycle's word is not itself the last.
    assign w_mark     = w_end && !w_we && (r_cnt != '0);
    assign w_prev_ptr = r_wr_ptr - ADDR_W'(1);
    assign w_commit   = (r_state == S_VERDICT) && !SyncIn && CrcOk && !r_ovf;
    assign w_commit_ptr = w_commit ? r_wr_ptr : r_commit_ptr;

    // Reading against the next commit pointer saves a cycle of release latency.
    assign w_avail   = r_rd_ptr != w_commit_ptr;
    assign w_out_ld  = !r_m_valid || M_Ready;
    assign w_s1_free = !r_s1_v || w_out_ld;
    assign w_rd      = w_avail && w_s1_free;

`ifdef CRC_FRAME_GATE_STRIP_EN
    assign w_s1_data = r_s1_last ? {r_s1_word[31:16], 16'h0000} : r_s1_word[31:0];
    assign w_s1_keep = r_s1_last ? 4'hC : r_s1_word[35:32];
`else
    assign w_s1_data = r_s1_word[31:0];
    assign w_s1_keep = r_s1_word[35:32];
`endif

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr]   <= {DinKeep, Din};
            r_lastv[r_wr_ptr] <= w_wlast;
        end
        if (w_mark) begin
            r_lastv[w_prev_ptr] <= 1'b1;
        end
        if (w_rd) begin
            r_s1_word <= r_mem[r_rd_ptr];
            r_s1_last <= r_lastv[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_crc_bad    <= 1'b0;
            r_good       <= '0;
            r_bad        <= '0;
            r_ovfc       <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                r_cnt    <= r_cnt + CNT_W'(1);
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (SyncIn) begin
                        r_state <= S_RECV;
                    end
                end
                S_RECV: begin
                    if (w_abort) begin
                        r_wr_ptr <= r_commit_ptr;
                        r_cnt    <= '0;
                        r_ovf    <= 1'b0;
                        r_bad    <= r_bad + 16'd1;
                    end else if (w_end) begin
                        r_state <= S_VERDICT;
                    end
                end
                S_VERDICT: begin
                    if (w_abort) begin
                        r_wr_ptr <= r_commit_ptr;
                        r_cnt    <= '0;
                        r_ovf    <= 1'b0;
                        r_bad    <= r_bad + 16'd1;
                        r_state  <= S_RECV;
                    end else if (w_commit) begin
                        r_commit_ptr <= r_wr_ptr;
                        r_good       <= r_good + 16'd1;
                        r_cnt        <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_crc_bad <= !CrcOk;
                        r_state   <= S_ROLLBACK;
                    end
                end
                S_ROLLBACK: begin
                    r_wr_ptr <= r_commit_ptr;
                    r_cnt    <= '0;
                    r_ovf    <= 1'b0;
                    if (r_crc_bad) begin
                        r_bad <= r_bad + 16'd1;
                    end else begin
                        r_ovfc <= r_ovfc + 16'd1;
                    end
                    r_state <= SyncIn ? S_RECV : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_rd_ptr  <= '0;
            r_s1_v    <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_sof   <= 1'b0;
            r_first   <= 1'b1;
        end else begin
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_s1_free) begin
                r_s1_v <= w_rd;
            end
            if (w_out_ld) begin
                r_m_valid <= r_s1_v;
                if (r_s1_v) begin
                    r_m_data <= w_s1_data;
                    r_m_keep <= w_s1_keep;
                    r_m_last <= r_s1_last;
                    r_m_sof  <= r_first;
                    r_first  <= r_s1_last;
                end
            end
        end
    end

    assign M_Valid = r_m_valid;
    assign M_Data  = r_m_data;
    assign M_Keep  = r_m_keep;
    assign M_Last  = r_m_last;
    assign M_Sof   = r_m_sof;
    assign GoodCnt = r_good;
    assign BadCnt  = r_bad;
    assign OvfCnt  = r_ovfc;
    assign Busy    = r_state != S_IDLE;

endmodule

// File: tb/tb_crc_frame_gate.sv
// Bench for crc_frame_gate: directed and random frames checked against a
// frame-level queue model of what should leave the gate.
module tb_crc_frame_gate;

    localparam int AW   = 4;
    localparam int MAXW = 12;

    logic        clk = 1'b0;
    logic        Rst;
    logic        SyncIn;
    logic        DinNd;
    logic [31:0] Din;
    logic [3:0]  DinKeep;
    logic        CrcSync;
    logic        CrcOk;
    logic        M_Ready;
    logic        M_Valid;
    logic [31:0] M_Data;
    logic [3:0]  M_Keep;
    logic        M_Last;
    logic        M_Sof;
    logic [15:0] GoodCnt;
    logic [15:0] BadCnt;
    logic [15:0] OvfCnt;
    logic        Busy;

    crc_frame_gate #(.ADDR_W(AW), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .Rst(Rst), .SyncIn(SyncIn), .DinNd(DinNd), .Din(Din),
        .DinKeep(DinKeep), .CrcSync(CrcSync), .CrcOk(CrcOk),
        .M_Valid(M_Valid), .M_Ready(M_Ready), .M_Data(M_Data),
        .M_Keep(M_Keep), .M_Last(M_Last), .M_Sof(M_Sof),
        .GoodCnt(GoodCnt), .BadCnt(BadCnt), .OvfCnt(OvfCnt), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        s;
    } beat_t;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    good = 0, bad = 0, ovf = 0;
    bit    first = 1'b1;
    int    rmode = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_good"}, 64'(GoodCnt), 64'(16'(good)));
        chk({tag, "_bad"},  64'(BadCnt),  64'(16'(bad)));
        chk({tag, "_ovf"},  64'(OvfCnt),  64'(16'(ovf)));
    endtask

    function automatic void push(input logic [31:0] d, input logic [3:0] k, input bit last);
        beat_t b;
`ifdef CRC_FRAME_GATE_STRIP_EN
        if (last) begin
            d[15:0] = 16'h0000;
            k = 4'hC;
        end
`endif
        b.d = d;
        b.k = k;
        b.l = last;
        b.s = first;
        first = last;
        q.push_back(b);
    endfunction

    // Output monitor: every transfer must match the model, stalls must hold.
    initial begin
        beat_t prev;
        beat_t obs;
        beat_t exp;
        bit    stall;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            obs = {M_Data, M_Keep, M_Last, M_Sof};
            if (Rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", 64'(M_Valid), 64'(1));
                    chk("hold_data", 64'(obs), 64'(prev));
                end
                if (M_Valid && M_Ready) begin
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $error("FAIL unexpected_beat observed=%h expected=none", obs);
                    end else begin
                        exp = q.pop_front();
                        chk("beat", 64'(obs), 64'(exp));
                    end
                end
                stall = M_Valid && !M_Ready;
                prev  = obs;
            end
        end
    end

    initial begin
        M_Ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: M_Ready = 1'b0;
                1: M_Ready = 1'b1;
                2: M_Ready = ~M_Ready;
                default: M_Ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic close_frame(input bit ok, input bit commit, input bit lat);
        @(posedge clk); #1;
        SyncIn  = 1'b0;
        DinNd   = 1'b0;
        CrcSync = 1'b1;
        @(posedge clk); #1;
        CrcSync = 1'b0;
        CrcOk   = ok;
        @(posedge clk); #1;
        CrcOk = 1'b0;
        if (lat) begin
            @(negedge clk);
            chk("lat_low", 64'(M_Valid), 64'(0));
            @(negedge clk);
            chk("lat_high", 64'(M_Valid), 64'(1));
        end
        if (commit) good++;
        else if (!ok) bad++;
        else ovf++;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int n, input bit ok, input bit fixed,
                              input bit gaps, input bit lead, input bit lat);
        bit          commit;
        logic [31:0] w;
        logic [3:0]  k;
        commit = ok && (n <= MAXW);
        if (lead) begin
            @(posedge clk); #1;
            CrcSync = 1'b1;
            @(posedge clk); #1;
            CrcSync = 1'b0;
            DinNd   = 1'b1;
            Din     = $urandom;
            @(posedge clk); #1;
            DinNd  = 1'b0;
            SyncIn = 1'b1;
            @(posedge clk); #1;
            SyncIn  = 1'b0;
            CrcSync = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            SyncIn  = 1'b0;
            DinNd   = 1'b0;
            CrcSync = 1'b0;
            if (gaps && i > 0) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
            if (fixed) w = (i == n - 1) ? 32'h4444ABCD : 32'h11111111 * 32'(i + 1);
            else w = $urandom;
            k = fixed ? 4'hF : 4'($urandom);
            SyncIn  = (i == 0) && !lead;
            DinNd   = 1'b1;
            Din     = w;
            DinKeep = k;
            if (commit) push(w, k, i == n - 1);
        end
        close_frame(ok, commit, lat);
    endtask

    task automatic abort_frame(input int nb);
        logic [31:0] w;
        logic [3:0]  k;
        @(posedge clk); #1;
        SyncIn = 1'b1; DinNd = 1'b1; Din = $urandom;
        @(posedge clk); #1;
        SyncIn = 1'b0; Din = $urandom;
        @(posedge clk); #1;
        SyncIn = 1'b1; Din = $urandom;
        bad++;
        for (int i = 0; i < nb; i++) begin
            @(posedge clk); #1;
            w = $urandom;
            k = 4'($urandom);
            SyncIn = 1'b0; DinNd = 1'b1; Din = w; DinKeep = k;
            push(w, k, i == nb - 1);
        end
        close_frame(1'b1, 1'b1, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 400 && q.size() != 0; c++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_drain"}, 64'(q.size()), 64'(0));
    endtask

    initial begin
        Rst = 1'b1; SyncIn = 1'b0; DinNd = 1'b0; Din = '0; DinKeep = '0;
        CrcSync = 1'b0; CrcOk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        Rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(M_Valid), 64'(0));
        chk("rst_busy", 64'(Busy), 64'(0));
        chk_cnt("rst");

        rmode = 1;
        send_frame(4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        drain("good");
        chk_cnt("good");

        send_frame(4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain("bad");
        chk_cnt("bad");
        send_frame(4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drain("after_bad");
        chk_cnt("after_bad");

        rmode = 0;
        send_frame(20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("ovf20");
        repeat (5) @(posedge clk);
        rmode = 1;
        drain("ovf20");
        send_frame(MAXW, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("max");
        send_frame(MAXW + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("max1");
        chk_cnt("max");

        send_frame(2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        drain("lead");
        chk_cnt("lead");

        rmode = 2;
        send_frame(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("bp");
        chk_cnt("bp");

        rmode = 1;
        abort_frame(3);
        drain("abort");
        chk_cnt("abort");

        rmode = 3;
        repeat (24) begin
            send_frame($urandom_range(1, MAXW + 2), $urandom_range(0, 3) != 0,
                       1'b0, 1'b1, 1'b0, 1'b0);
            drain("rand");
        end
        chk_cnt("rand");

        rmode = 0;
        send_frame(5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        SyncIn = 1'b1; DinNd = 1'b1; Din = $urandom;
        @(posedge clk); #1;
        SyncIn = 1'b0; Din = $urandom;
        @(negedge clk);
        chk("midframe_busy", 64'(Busy), 64'(1));
        @(posedge clk); #1;
        DinNd = 1'b0;
        Rst = 1'b1;
        q.delete();
        first = 1'b1;
        good = 0; bad = 0; ovf = 0;
        @(posedge clk); #1;
        Rst = 1'b0;
        @(negedge clk);
        chk("mrst_out", 64'({M_Valid, M_Data, M_Keep, M_Last, M_Sof, Busy}), 64'(0));
        chk_cnt("mrst");

        rmode = 1;
        send_frame(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drain("post_rst");
        chk_cnt("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
